// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared FP field widths, special constants, flag indices, operand class.
// Revision : 1.0
// ============================================================================
package fp_pkg;

  localparam int c_FP_EXP_W = 8;
  localparam int c_FP_MAN_W = 23;

  // Single-precision reference encodings
  localparam logic [31:0] c_QNAN_SP = 32'h7FC0_0000;
  localparam logic [31:0] c_INF_SP  = 32'h7F80_0000;

  localparam int c_FLAG_INVALID   = 2;
  localparam int c_FLAG_OVERFLOW  = 1;
  localparam int c_FLAG_UNDERFLOW = 0;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_operand_t;

  function automatic fp_operand_t fp_classify(input logic sign, input logic exp_zero,
                                              input logic exp_ones, input logic man_zero);
    fp_operand_t r;
    r.sign    = sign;
    r.is_zero = exp_zero;
    r.is_inf  = exp_ones & man_zero;
    r.is_nan  = exp_ones & ~man_zero;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc_norm.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc_norm
// Brief    : Leading-zero count and left shift so the leading one lands at the MSB.
// Revision : 1.0
// ============================================================================
module fp_lzc_norm
  import fp_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] norm
);

  // Upward scan: the highest set bit is the last to overwrite the count
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign norm = data << count;

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Brief    : 3-stage FP adder/subtractor (align, add, normalize/pack).
//            Macro FP_ADDSUB_ROUND_EN selects round-nearest-even; default truncates.
// Revision : 1.0
// ============================================================================
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = c_FP_EXP_W,
  parameter int MAN_W = c_FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MX  = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int SW  = MX + 1;             // plus carry
  localparam int LZW = $clog2(SW) + 1;
  localparam int EW2 = EXP_W + 2;
  localparam logic [W-1:0]   c_QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW2-1:0] c_EXP_MAX = EW2'((2**EXP_W) - 1);

  logic w_en1, w_en2, w_en3;
  logic r1_valid, r2_valid, r3_valid;

  assign w_en3    = !r3_valid || out_ready;
  assign w_en2    = !r2_valid || w_en3;
  assign w_en1    = !r1_valid || w_en2;
  assign in_ready = w_en1;

  // ---------------- S1: classify, swap, align ----------------
  logic [EXP_W-1:0] w_ea, w_eb, w_big_exp, w_sml_exp, w_diff;
  logic [MAN_W-1:0] w_ma, w_mb, w_ma_f, w_mb_f;
  logic [MX-1:0]    w_big_ext, w_sml_ext, w_sml_al, w_sml_fin;
  logic [2*MX-1:0]  w_wide;
  logic             w_big_sign, w_sub, w_a_ge, w_sticky;
  logic             w_nan, w_inf;
  logic [W-1:0]     w_spec_word;
  logic [2:0]       w_spec_flags;
  fp_operand_t      w_opa, w_opb;

  assign w_ea  = dataa[W-2 -: EXP_W];
  assign w_eb  = datab[W-2 -: EXP_W];
  assign w_ma  = dataa[MAN_W-1:0];
  assign w_mb  = datab[MAN_W-1:0];
  assign w_opa = fp_classify(dataa[W-1], w_ea == '0, &w_ea, w_ma == '0);
  assign w_opb = fp_classify(datab[W-1] ^ op, w_eb == '0, &w_eb, w_mb == '0);
  assign w_ma_f = w_opa.is_zero ? '0 : w_ma;
  assign w_mb_f = w_opb.is_zero ? '0 : w_mb;
  assign w_a_ge = {w_ea, w_ma_f} >= {w_eb, w_mb_f};
  assign w_sub  = w_opa.sign ^ w_opb.sign;

  always_comb begin
    if (w_a_ge) begin
      w_big_sign = w_opa.sign;
      w_big_exp  = w_ea;
      w_big_ext  = {~w_opa.is_zero, w_ma_f, 3'b000};
      w_sml_exp  = w_eb;
      w_sml_ext  = {~w_opb.is_zero, w_mb_f, 3'b000};
    end else begin
      w_big_sign = w_opb.sign;
      w_big_exp  = w_eb;
      w_big_ext  = {~w_opb.is_zero, w_mb_f, 3'b000};
      w_sml_exp  = w_ea;
      w_sml_ext  = {~w_opa.is_zero, w_ma_f, 3'b000};
    end
  end

  assign w_diff = w_big_exp - w_sml_exp;
  assign w_wide = {w_sml_ext, {MX{1'b0}}} >> w_diff;

  // Far-apart operands contribute only a sticky bit
  always_comb begin
    if (32'(w_diff) >= MAN_W + 3) begin
      w_sml_al = '0;
      w_sticky = |w_sml_ext;
    end else begin
      w_sml_al = w_wide[2*MX-1:MX];
      w_sticky = |w_wide[MX-1:0];
    end
  end
  assign w_sml_fin = w_sml_al | {{(MX-1){1'b0}}, w_sticky};

  always_comb begin
    w_nan        = w_opa.is_nan | w_opb.is_nan | (w_opa.is_inf & w_opb.is_inf & w_sub);
    w_inf        = w_opa.is_inf | w_opb.is_inf;
    w_spec_flags = '0;
    w_spec_flags[c_FLAG_INVALID] = w_nan;
    if (w_nan) w_spec_word = c_QNAN;
    else       w_spec_word = {w_opa.is_inf ? w_opa.sign : w_opb.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic             r1_sign, r1_sub, r1_spec;
  logic [EXP_W-1:0] r1_exp;
  logic [MX-1:0]    r1_big, r1_small;
  logic [W-1:0]     r1_spec_word;
  logic [2:0]       r1_spec_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid      <= 1'b0;
      r1_sign       <= 1'b0;
      r1_sub        <= 1'b0;
      r1_spec       <= 1'b0;
      r1_exp        <= '0;
      r1_big        <= '0;
      r1_small      <= '0;
      r1_spec_word  <= '0;
      r1_spec_flags <= '0;
    end else if (w_en1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign       <= w_big_sign;
        r1_sub        <= w_sub;
        r1_spec       <= w_nan | w_inf;
        r1_exp        <= w_big_exp;
        r1_big        <= w_big_ext;
        r1_small      <= w_sml_fin;
        r1_spec_word  <= w_spec_word;
        r1_spec_flags <= w_spec_flags;
      end
    end
  end

  // ---------------- S2: mantissa add/sub ----------------
  logic             r2_sign, r2_sub, r2_spec;
  logic [EXP_W-1:0] r2_exp;
  logic [SW-1:0]    r2_sum;
  logic [W-1:0]     r2_spec_word;
  logic [2:0]       r2_spec_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid      <= 1'b0;
      r2_sign       <= 1'b0;
      r2_sub        <= 1'b0;
      r2_spec       <= 1'b0;
      r2_exp        <= '0;
      r2_sum        <= '0;
      r2_spec_word  <= '0;
      r2_spec_flags <= '0;
    end else if (w_en2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign       <= r1_sign;
        r2_sub        <= r1_sub;
        r2_spec       <= r1_spec;
        r2_exp        <= r1_exp;
        r2_sum        <= r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                                : ({1'b0, r1_big} + {1'b0, r1_small});
        r2_spec_word  <= r1_spec_word;
        r2_spec_flags <= r1_spec_flags;
      end
    end
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [LZW-1:0]   w_lz;
  logic [SW-1:0]    w_norm;
  logic [EW2-1:0]   w_exp_pre, w_exp_fin;
  logic [MAN_W:0]   w_man_r;
  logic             w_round_up, w_unused;
  logic [W-1:0]     w_res;
  logic [2:0]       w_flags;

  fp_lzc_norm #(
    .WIDTH (SW),
    .CNT_W (LZW)
  ) u_norm (
    .data  (r2_sum),
    .count (w_lz),
    .norm  (w_norm)
  );

  // Leading one ends at the top bit; the pre-shift carry position is exponent +1
  assign w_exp_pre = EW2'(r2_exp) + EW2'(1) - EW2'(w_lz);

`ifdef FP_ADDSUB_ROUND_EN
  assign w_round_up = w_norm[3] & (w_norm[2] | w_norm[1] | w_norm[0] | w_norm[4]);
  assign w_unused   = w_norm[SW-1];
`else
  assign w_round_up = 1'b0;
  assign w_unused   = ^{w_norm[SW-1], w_norm[3:0]};
`endif

  assign w_man_r   = {1'b0, w_norm[SW-2 -: MAN_W]} + (MAN_W+1)'(w_round_up);
  assign w_exp_fin = w_exp_pre + EW2'(w_man_r[MAN_W]);

  always_comb begin
    w_flags = '0;
    w_res   = {r2_sign, w_exp_fin[EXP_W-1:0], w_man_r[MAN_W-1:0]};
    if (r2_spec) begin
      w_res   = r2_spec_word;
      w_flags = r2_spec_flags;
    end else if (r2_sum == '0) begin
      w_res = {r2_sign & ~r2_sub, {(W-1){1'b0}}};
    end else if (w_exp_fin[EW2-1] || w_exp_fin == '0) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_flags[c_FLAG_UNDERFLOW] = 1'b1;
    end else if (w_exp_fin >= c_EXP_MAX) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags[c_FLAG_OVERFLOW] = 1'b1;
    end
  end

  logic [W-1:0] r3_result;
  logic [2:0]   r3_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_flags  <= '0;
    end else if (w_en3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_result <= w_res;
        r3_flags  <= w_flags;
      end
    end
  end

  assign out_valid = r3_valid;
  assign result    = r3_result;
  assign flags     = r3_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Brief    : Directed self-checking bench for fp_addsub_pipe (single precision).
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One isolated op with out_ready high; result expected in the 3rd cycle after transfer
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] er, input logic [2:0] ef,
                       input bit chk_lat);
    @(negedge clk);
    dataa = a; datab = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (chk_lat) check({tag, " lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    if (chk_lat) check({tag, " lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, 32'(flags), 32'(ef));
  endtask

  logic [31:0] s_a [6] = '{32'h3F800000, 32'h40000000, 32'h3F800000,
                           32'h40400000, 32'h3F800000, 32'h3F000000};
  logic [31:0] s_b [6] = '{32'h3F800000, 32'h40000000, 32'h40000000,
                           32'h3F800000, 32'h3F000000, 32'h3E800000};
  logic        s_o [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] s_r [6] = '{32'h40000000, 32'h40800000, 32'h40400000,
                           32'h40000000, 32'h3F000000, 32'h3F400000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx, out_idx, n_stale;
    bit saw_low;

    repeat (3) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'h0);
    check("rst flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    #1 check("rst in_ready", 32'(in_ready), 32'd1);

    do_op("add 1+2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    do_op("3-3", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b000, 1'b0);
    do_op("1+-0.75", 32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 3'b000, 1'b0);
    do_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, 1'b0);
    do_op("inf-inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1'b0);
    do_op("nan+1", 32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1'b0);
    do_op("1-inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 1'b0);
    do_op("1-1.5", 32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 3'b000, 1'b0);
    do_op("unf", 32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 3'b001, 1'b0);
    do_op("denorm", 32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000, 1'b0);
`ifdef FP_ADDSUB_ROUND_EN
    do_op("round", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, 1'b0);
    do_op("far sub", 32'h4C800000, 32'h3F800000, 1'b1, 32'h4C800000, 3'b000, 1'b0);
`else
    do_op("round", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 3'b000, 1'b0);
    do_op("far sub", 32'h4C800000, 32'h3F800000, 1'b1, 32'h4C7FFFFF, 3'b000, 1'b0);
`endif

    // Back-to-back stream with a five-cycle output stall
    in_idx = 0; out_idx = 0; saw_low = 1'b0;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 6);
      if (in_idx < 6) begin
        in_valid = 1'b1; dataa = s_a[in_idx]; datab = s_b[in_idx]; op = s_o[in_idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("stream ready c2", 32'(in_ready), 32'd1);
      if (c == 3) check("stream ready c3", 32'(in_ready), 32'd0);
      if (!in_ready) saw_low = 1'b1;
      if (out_valid) begin
        check($sformatf("stream res %0d", out_idx), result, s_r[out_idx]);
        check($sformatf("stream flags %0d", out_idx), 32'(flags), 32'd0);
        if (out_ready) out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream outputs", 32'(out_idx), 32'd6);
    check("stream inputs", 32'(in_idx), 32'd6);
    check("stream in_ready dropped", 32'(saw_low), 32'd1);

    // Reset with three ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; dataa = s_a[k]; datab = s_b[k]; op = s_o[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst result", result, 32'h0);
    check("mid-rst flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) n_stale++;
    end
    check("post-rst stale", 32'(n_stale), 32'd0);
    do_op("post-rst op", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
